// File: rtl/demand_detector.sv
// Request front end: synchronises and debounces raw sensor/button levels, latches demand
// per channel until served, counts wait seconds and reports the longest-waiting channel.
module demand_detector #(
   parameter int unsigned N_REQ         = 6,
   parameter int unsigned DEBOUNCE      = 20,
   parameter int unsigned TICKS_PER_SEC = 1000,
   parameter int unsigned WAIT_W        = 8,
   localparam int unsigned IDX_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic [N_REQ-1:0]        raw_in,
   input  logic [N_REQ-1:0]        serve,
   output logic [N_REQ-1:0]        demand,
   output logic [N_REQ*WAIT_W-1:0] wait_sec,
   output logic                    any_demand,
   output logic [IDX_W-1:0]        oldest_idx
);

   localparam int unsigned PSC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int unsigned DEB_W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [PSC_W-1:0]  PSC_LAST = PSC_W'(TICKS_PER_SEC - 1);
   localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEBOUNCE - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = '1;

   typedef enum logic [1:0] {StIdle, StQual, StPending, StServing} ch_state_e;

   logic [PSC_W-1:0]  psc_q;
   logic              tick;
   logic [WAIT_W-1:0] wait_arr [N_REQ];

   assign tick = (psc_q == PSC_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         psc_q <= '0;
      end else if (tick) begin
         psc_q <= '0;
      end else begin
         psc_q <= psc_q + 1'b1;
      end
   end

   for (genvar g = 0; g < N_REQ; g++) begin : g_ch
      logic [1:0]        sync_q;
      ch_state_e         state_q;
      logic [DEB_W-1:0]  deb_cnt_q;
      logic [WAIT_W-1:0] wait_q;
      logic              demand_q;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            sync_q    <= '0;
            state_q   <= StIdle;
            deb_cnt_q <= '0;
            wait_q    <= '0;
            demand_q  <= 1'b0;
         end else begin
            sync_q   <= {sync_q[0], raw_in[g]};
            // serve drops demand on the same edge it is sampled
            demand_q <= (state_q == StPending) && !serve[g];
            if (serve[g]) begin
               state_q   <= StServing;
               deb_cnt_q <= '0;
               wait_q    <= '0;
            end else begin
               case (state_q)
                  StIdle: begin
                     if (sync_q[1]) begin
                        state_q   <= StQual;
                        deb_cnt_q <= DEB_W'(1);
                     end
                  end
                  StQual: begin
                     if (!sync_q[1]) begin
                        state_q   <= StIdle;
                        deb_cnt_q <= '0;
                     end else if (deb_cnt_q == DEB_LAST) begin
                        state_q <= StPending;
                     end else begin
                        deb_cnt_q <= deb_cnt_q + 1'b1;
                     end
                  end
                  StPending: begin
                     if (tick && (wait_q != WAIT_MAX)) begin
                        wait_q <= wait_q + 1'b1;
                     end
                  end
                  StServing: begin
                     state_q   <= StIdle;
                     deb_cnt_q <= '0;
                  end
                  default: state_q <= StIdle;
               endcase
            end
         end
      end

      assign demand[g]                     = demand_q;
      assign wait_sec[g*WAIT_W +: WAIT_W]  = wait_q;
      assign wait_arr[g]                   = wait_q;
   end

   assign any_demand = |demand;

   logic [IDX_W-1:0]  oldest_d;
   logic [WAIT_W-1:0] best_wait;
   logic              found;

   // strict compare keeps the lowest index on ties
   always_comb begin
      oldest_d  = '0;
      best_wait = '0;
      found     = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (demand[i] && (!found || (wait_arr[i] > best_wait))) begin
            found     = 1'b1;
            best_wait = wait_arr[i];
            oldest_d  = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         oldest_idx <= '0;
      end else begin
         oldest_idx <= oldest_d;
      end
   end

endmodule
